// File: rtl/loop_pkg.sv
// Shared definitions for the arithmetic-loop harness: the unwinder state encoding,
// its error codes, and the default loop bounds it shares with the forward stepper.
package loop_pkg;

   localparam int unsigned LOOP_W      = 15;
   localparam int unsigned LOOP_INIT_I = 1;
   localparam int unsigned LOOP_INIT_J = 1000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CHECK,
      ST_UNWIND,
      ST_DONE,
      ST_FAIL
   } loop_unw_state_t;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_BASE = 2'b01;
   localparam logic [1:0] ERR_INV  = 2'b10;

endpackage

// File: rtl/loop_invariant_chk.sv
// Combinational trajectory check for the i += 2 / j -= 1 loop.
// base_ok : i is at or above the start value and has the start value's parity.
// inv_ok  : i + 2j equals the loop invariant INIT_I + 2*INIT_J, computed without truncation.
// at_base : i sits exactly on the start value.
module loop_invariant_chk
   import loop_pkg::*;
#(
   parameter int unsigned W      = LOOP_W,
   parameter int unsigned INIT_I = LOOP_INIT_I,
   parameter int unsigned INIT_J = LOOP_INIT_J
) (
   input  logic [W-1:0] i,
   input  logic [W-1:0] j,
   output logic         base_ok,
   output logic         inv_ok,
   output logic         at_base
);

   localparam logic [W-1:0] I0     = W'(INIT_I);
   localparam logic [W+1:0] TARGET = (W+2)'(INIT_I + 2 * INIT_J);

   logic [W+1:0] sum;

   // Invariant sum and comparisons against the loop start point
   always_comb begin
      sum     = {2'b00, i} + {1'b0, j, 1'b0};
      base_ok = (i >= I0) && (i[0] == I0[0]);
      inv_ok  = (sum == TARGET);
      at_base = (i == I0);
   end

endmodule

// File: rtl/loop_unwinder.sv
// Reverse companion to the forward loop stepper: loads a captured (i, j),
// checks it lies on the loop trajectory, then steps it back to (INIT_I, INIT_J)
// one selector-enabled cycle at a time while counting the steps taken.
module loop_unwinder
   import loop_pkg::*;
#(
   parameter int unsigned W      = LOOP_W,
   parameter int unsigned INIT_I = LOOP_INIT_I,
   parameter int unsigned INIT_J = LOOP_INIT_J
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] i_in,
   input  logic [W-1:0] j_in,
   input  logic         selector,
   output logic [W-1:0] i,
   output logic [W-1:0] j,
   output logic [W-1:0] steps,
   output logic         busy,
   output logic         done,
   output logic         terminal,
   output logic         err,
   output logic [1:0]   err_code
);

   localparam logic [W-1:0] I0     = W'(INIT_I);
   localparam logic [W-1:0] J0     = W'(INIT_J);
   localparam logic [W-1:0] I_LAST = W'(INIT_I + 2);
   localparam logic [W-1:0] ONE    = W'(1);
   localparam logic [W-1:0] TWO    = W'(2);

   loop_unw_state_t state, state_n;
   logic [W-1:0]    i_n, j_n, steps_n;
   logic            term_n;
   logic [1:0]      code_n;
   logic            base_ok, inv_ok, at_base;
   logic            term_load;
   logic [W+1:0]    i_ext, j_ext;

   loop_invariant_chk #(
      .W      (W),
      .INIT_I (INIT_I),
      .INIT_J (INIT_J)
   ) u_chk (
      .i       (i),
      .j       (j),
      .base_ok (base_ok),
      .inv_ok  (inv_ok),
      .at_base (at_base)
   );

   // Exit-state test on the loaded values; j+1 >= i-2 is rearranged as j+3 >= i
   // in widened arithmetic so small i cannot wrap.
   always_comb begin
      i_ext     = {2'b00, i_in};
      j_ext     = {2'b00, j_in};
      term_load = (j_in < i_in) && ((j_ext + (W+2)'(3)) >= i_ext);
   end

   // Next-state and datapath update
   always_comb begin
      state_n = state;
      i_n     = i;
      j_n     = j;
      steps_n = steps;
      term_n  = terminal;
      code_n  = err_code;
      case (state)
         ST_IDLE, ST_DONE, ST_FAIL: begin
            if (start) begin
               i_n     = i_in;
               j_n     = j_in;
               steps_n = '0;
               term_n  = term_load;
               code_n  = ERR_NONE;
               state_n = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (!base_ok) begin
               code_n  = ERR_BASE;
               state_n = ST_FAIL;
            end else if (!inv_ok) begin
               code_n  = ERR_INV;
               state_n = ST_FAIL;
            end else if (at_base) begin
               state_n = ST_DONE;
            end else begin
               state_n = ST_UNWIND;
            end
         end
         ST_UNWIND: begin
            if (selector) begin
               i_n     = i - TWO;
               j_n     = j + ONE;
               steps_n = steps + ONE;
               if (i == I_LAST) begin
                  state_n = ST_DONE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // State and datapath registers, synchronous active-high reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         i        <= I0;
         j        <= J0;
         steps    <= '0;
         terminal <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         state    <= state_n;
         i        <= i_n;
         j        <= j_n;
         steps    <= steps_n;
         terminal <= term_n;
         err_code <= code_n;
      end
   end

   // Status flags decoded from the registered state only
   always_comb begin
      busy = (state == ST_CHECK) || (state == ST_UNWIND);
      done = (state == ST_DONE);
      err  = (state == ST_FAIL);
   end

endmodule

// File: tb/tb_loop_unwinder.sv
// Directed bench for loop_unwinder with hand-computed expected values.
module tb_loop_unwinder;

   logic        clk;
   logic        rst;
   logic        start;
   logic [14:0] i_in;
   logic [14:0] j_in;
   logic        selector;
   logic [14:0] i;
   logic [14:0] j;
   logic [14:0] steps;
   logic        busy;
   logic        done;
   logic        terminal;
   logic        err;
   logic [1:0]  err_code;

   int errors = 0;
   int checks = 0;

   loop_unwinder #(
      .W      (15),
      .INIT_I (1),
      .INIT_J (1000)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .i_in     (i_in),
      .j_in     (j_in),
      .selector (selector),
      .i        (i),
      .j        (j),
      .steps    (steps),
      .busy     (busy),
      .done     (done),
      .terminal (terminal),
      .err      (err),
      .err_code (err_code)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, ".i"},        32'(i), 32'd1);
      chk({tag, ".j"},        32'(j), 32'd1000);
      chk({tag, ".steps"},    32'(steps), 32'd0);
      chk({tag, ".busy"},     32'(busy), 32'd0);
      chk({tag, ".done"},     32'(done), 32'd0);
      chk({tag, ".terminal"}, 32'(terminal), 32'd0);
      chk({tag, ".err"},      32'(err), 32'd0);
      chk({tag, ".err_code"}, 32'(err_code), 32'd0);
   endtask

   // Ticks until done or err rises; returns the edge count, limit+1 on timeout
   task automatic wait_end(input int limit, output int edges);
      edges = limit + 1;
      for (int e = 1; e <= limit; e++) begin
         tick();
         if (done || err) begin
            edges = e;
            break;
         end
      end
   endtask

   task automatic load(input int ii, input int jj);
      i_in  = 15'(ii);
      j_in  = 15'(jj);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   initial begin
      int edges;
      int exp_s;

      rst      = 1'b1;
      start    = 1'b0;
      i_in     = '0;
      j_in     = '0;
      selector = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      repeat (5) tick();
      chk_reset_state("reset");

      // Exit state (669,666): 334 steps back to the base
      selector = 1'b1;
      load(669, 666);
      chk("long.busy0", 32'(busy), 32'd1);
      chk("long.done0", 32'(done), 32'd0);
      wait_end(400, edges);
      chk("long.edges", 32'(edges), 32'd335);
      chk("long.done", 32'(done), 32'd1);
      chk("long.i", 32'(i), 32'd1);
      chk("long.j", 32'(j), 32'd1000);
      chk("long.steps", 32'(steps), 32'd334);
      chk("long.terminal", 32'(terminal), 32'd1);
      chk("long.err", 32'(err), 32'd0);
      chk("long.busy", 32'(busy), 32'd0);
      tick();
      chk("long.hold_done", 32'(done), 32'd1);
      chk("long.hold_steps", 32'(steps), 32'd334);

      // Already at base: done after one edge
      load(1, 1000);
      wait_end(10, edges);
      chk("base.edges", 32'(edges), 32'd1);
      chk("base.done", 32'(done), 32'd1);
      chk("base.steps", 32'(steps), 32'd0);
      chk("base.terminal", 32'(terminal), 32'd0);
      chk("base.i", 32'(i), 32'd1);

      // Invariant mismatch
      load(669, 667);
      wait_end(10, edges);
      chk("inv.edges", 32'(edges), 32'd1);
      chk("inv.err", 32'(err), 32'd1);
      chk("inv.code", 32'(err_code), 32'd2);
      chk("inv.done", 32'(done), 32'd0);
      tick();
      chk("inv.hold_err", 32'(err), 32'd1);

      // Below base: base check takes priority over invariant
      load(0, 1000);
      wait_end(10, edges);
      chk("base_lo.edges", 32'(edges), 32'd1);
      chk("base_lo.err", 32'(err), 32'd1);
      chk("base_lo.code", 32'(err_code), 32'd1);

      // Wrong parity with otherwise plausible value
      load(2, 999);
      wait_end(10, edges);
      chk("parity.code", 32'(err_code), 32'd1);

      // (21,990) with selector alternating; stray start mid-UNWIND
      selector = 1'b1;
      load(21, 990);
      for (int k = 1; k <= 21; k++) begin
         selector = k[0];
         start    = (k == 10);
         i_in     = 15'd5;
         j_in     = 15'd5;
         tick();
         start = 1'b0;
         if (k == 1) begin
            chk("alt.busy_check", 32'(busy), 32'd1);
         end else begin
            exp_s = (k - 1) / 2;
            chk($sformatf("alt.steps@%0d", k), 32'(steps), 32'(exp_s));
            chk($sformatf("alt.i@%0d", k), 32'(i), 32'(21 - 2 * exp_s));
            chk($sformatf("alt.j@%0d", k), 32'(j), 32'(990 + exp_s));
            chk($sformatf("alt.done@%0d", k), 32'(done), 32'(k == 21));
         end
      end
      chk("alt.terminal", 32'(terminal), 32'd0);
      chk("alt.err", 32'(err), 32'd0);

      // Reset mid-UNWIND wins over start and selector
      selector = 1'b1;
      load(669, 666);
      repeat (100) tick();
      chk("mid.steps99", 32'(steps), 32'd99);
      chk("mid.busy", 32'(busy), 32'd1);
      rst   = 1'b1;
      start = 1'b1;
      tick();
      rst   = 1'b0;
      start = 1'b0;
      chk_reset_state("midrst");

      // Fresh single-step unwind after reset
      load(3, 999);
      wait_end(10, edges);
      chk("one.edges", 32'(edges), 32'd2);
      chk("one.done", 32'(done), 32'd1);
      chk("one.steps", 32'(steps), 32'd1);
      chk("one.i", 32'(i), 32'd1);
      chk("one.j", 32'(j), 32'd1000);
      chk("one.terminal", 32'(terminal), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/loop_unwinder.md
# loop_unwinder

Reverse-direction companion to the forward loop stepper (i += 2, j -= 1 while j >= i, gated by selector). It accepts an (i, j) state captured from the forward block and checks that the state lies on the loop trajectory (invariant i + 2j = INIT_I + 2·INIT_J, parity, lower bound). It then walks the state back to (INIT_I, INIT_J) one step per enabled cycle, counting steps. It sits beside the forward stepper in the arithmetic-loop test harness as its consistency checker and undo engine.

## Interface
- W, 15, width of i/j datapath and step counter
- INIT_I, 1, loop start value of i
- INIT_J, 1000, loop start value of j

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  load request; sampled only in IDLE, DONE, FAIL
- i_in  in  W  captured forward-loop i
- j_in  in  W  captured forward-loop j
- selector  in  1  step enable during UNWIND (mirrors forward block)
- i  out  W  current unwound i
- j  out  W  current unwound j
- steps  out  W  number of reverse steps taken
- busy  out  1  high in CHECK and UNWIND
- done  out  1  high in DONE (level, not pulse)
- terminal  out  1  valid in DONE: loaded state was the forward loop's exit state
- err  out  1  high in FAIL
- err_code  out  2  01 = below base/parity, 10 = invariant mismatch, 00 otherwise

## Operation
- States: IDLE, CHECK, UNWIND, DONE, FAIL.
- IDLE/DONE/FAIL + start=1: i←i_in, j←j_in, steps←0, terminal←(j_in < i_in) && (j_in+1 ≥ i_in−2), err_code←00 → CHECK.
- start in CHECK or UNWIND: ignored.
- CHECK (exactly one cycle), priority order:
  - i < INIT_I or (i − INIT_I) odd → FAIL, err_code=01.
  - i + 2j ≠ INIT_I + 2·INIT_J → FAIL, err_code=10.
  - i == INIT_I → DONE.
  - else → UNWIND.
- UNWIND with selector=1: i←i−2, j←j+1, steps←steps+1; if i == INIT_I+2 before the step → DONE. With selector=0: all registers hold, state holds.
- DONE/FAIL: hold all outputs until start or rst.
- Arithmetic:
  - Invariant sum computed in W+2 bits, zero-extended, no truncation.
  - i − 2 never underflows, since CHECK guarantees i ≥ INIT_I+2 and correct parity.
  - j + 1 cannot overflow W bits, because the invariant bounds j ≤ INIT_J.

## Timing
- Reset values: state IDLE, i=INIT_I, j=INIT_J, steps=0, busy=0, done=0, terminal=0, err=0, err_code=00.
- rst in any state, including mid-UNWIND, wins over start/selector; reset values are visible after that edge.
- start sampled at edge 0 → CHECK after edge 0; UNWIND or DONE/FAIL after edge 1.
- With selector held high and N required steps, done=1 after edge N+1 (N=0: after edge 1).
- Each selector=0 cycle in UNWIND adds one cycle of latency.
- All outputs registered; no combinational input→output path.

## Structure
- Package loop_pkg:
  - state enum loop_unw_state_t;
  - err codes ERR_NONE/ERR_BASE/ERR_INV;
  - default INIT_I/INIT_J constants, shared with the forward stepper.
- One sub-module: loop_invariant_chk. It is combinational: (i, j) → base_ok, inv_ok, at_base. It is reusable by the forward-side monitor.
- Remainder is a single FSM + datapath in loop_unwinder.

## Test plan
- Reset, then idle 5 cycles → i=1, j=1000, steps=0, busy=done=err=0, err_code=00.
- start with (669,666), selector=1 → busy after edge 0; done after edge 335; i=1, j=1000, steps=334, terminal=1, err=0.
- start with (1,1000) → done after edge 1, steps=0, terminal=0.
- start with (669,667) → FAIL after edge 1, err_code=10. start with (0,1000) → FAIL, err_code=01 (base check has priority).
- start with (21,990), selector alternating 1/0 → steps=10 at done; i/j hold on every selector=0 cycle; done after edge 21; a start pulse mid-UNWIND is ignored.
- start with (669,666), assert rst at UNWIND step 100 → reset values after that edge. A fresh start with (3,999) then → done, steps=1, i=1, j=1000.
